// File: rtl/jk_ff_monitor.sv
// Clocked checker for a JK flip-flop stage: predicts next Q from a reference JK
// model, flags Q mismatches and Q/Q_bar complement violations, counts JK modes.
module jk_ff_monitor #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             j,
    input  logic             k,
    input  logic             q,
    input  logic             q_bar,
    output logic [CNT_W-1:0] hold_cnt,
    output logic [CNT_W-1:0] reset_cnt,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err,
    output logic             err_pulse,
    output logic [1:0]       first_err_mode,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        CHECK = 2'b01,
        FAULT = 2'b10
    } state_t;

    localparam logic [1:0] M_HOLD   = 2'b00;
    localparam logic [1:0] M_RESET  = 2'b01;
    localparam logic [1:0] M_SET    = 2'b10;
    localparam logic [1:0] M_TOGGLE = 2'b11;

    state_t                     cur_state;
    state_t                     nxt_state;
    logic [1:0]                 mode;
    logic [1:0]                 last_mode;
    logic                       exp_q;
    logic                       pred_q;
    logic                       count_en;
    logic                       check_en;
    logic                       fail;
    logic [3:0][CNT_W-1:0]      mode_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic jk_ref(input logic qv, input logic [1:0] m);
        case (m)
            M_HOLD:   return qv;
            M_RESET:  return 1'b0;
            M_SET:    return 1'b1;
            default:  return ~qv;
        endcase
    endfunction

    assign mode   = {j, k};
    assign pred_q = jk_ref(q, mode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur_state <= IDLE;
        else      cur_state <= nxt_state;
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (en) nxt_state = CHECK;
            CHECK: begin
                if (!en)                     nxt_state = IDLE;
                else if (fail && STOP_ON_ERR) nxt_state = FAULT;
            end
            FAULT:   nxt_state = FAULT;
            default: nxt_state = IDLE;
        endcase
    end

    // Case-inequality so an X/Z on q or q_bar in simulation reads as a failure.
    always_comb begin
        count_en = 1'b0;
        check_en = 1'b0;
        fail     = 1'b0;
        case (cur_state)
            IDLE:  count_en = en;
            CHECK: begin
                count_en = en;
                check_en = en;
                fail     = en && ((q !== exp_q) || (q_bar !== ~q));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_cnt <= '0;
        end else if (count_en) begin
            mode_cnt[mode] <= sat_inc(mode_cnt[mode]);
        end
    end

    // Reference resyncs to the observed q each edge so one fault does not cascade.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_q     <= 1'b0;
            last_mode <= 2'b00;
        end else if (count_en) begin
            exp_q     <= pred_q;
            last_mode <= mode;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pulse      <= 1'b0;
            err            <= 1'b0;
            err_cnt        <= '0;
            first_err_mode <= 2'b00;
        end else begin
            err_pulse <= fail;
            if (fail) begin
                err     <= 1'b1;
                err_cnt <= sat_inc(err_cnt);
                if (!err) first_err_mode <= last_mode;
            end
        end
    end

    assign hold_cnt   = mode_cnt[M_HOLD];
    assign reset_cnt  = mode_cnt[M_RESET];
    assign set_cnt    = mode_cnt[M_SET];
    assign toggle_cnt = mode_cnt[M_TOGGLE];
    assign state      = cur_state;

    logic unused_check;
    assign unused_check = check_en;

endmodule

// File: tb/tb_jk_ff_monitor.sv
// Scoreboard bench for jk_ff_monitor: two instances (CNT_W=4 free-running,
// CNT_W=8 stop-on-error) share stimulus and are checked against a JK event model.
module tb_jk_ff_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, j = 1'b0, k = 1'b0, q = 1'b0, q_bar = 1'b1;

    logic [3:0] h0, r0, s0, t0, e0;
    logic       err0, p0;
    logic [1:0] fm0, st0;
    logic [7:0] h1, r1, s1, t1, e1;
    logic       err1, p1;
    logic [1:0] fm1, st1;

    always #5 clk = ~clk;

    jk_ff_monitor #(.CNT_W(4), .STOP_ON_ERR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .j(j), .k(k), .q(q), .q_bar(q_bar),
        .hold_cnt(h0), .reset_cnt(r0), .set_cnt(s0), .toggle_cnt(t0), .err_cnt(e0),
        .err(err0), .err_pulse(p0), .first_err_mode(fm0), .state(st0)
    );

    jk_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .j(j), .k(k), .q(q), .q_bar(q_bar),
        .hold_cnt(h1), .reset_cnt(r1), .set_cnt(s1), .toggle_cnt(t1), .err_cnt(e1),
        .err(err1), .err_pulse(p1), .first_err_mode(fm1), .state(st1)
    );

    typedef struct {
        int h, r, s, t, e, er, p, fm, st;
    } obs_t;

    obs_t sb0[$];
    obs_t sb1[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: 0 idle, 1 checking, 2 fault; counts indexed by mode 0..3.
    int m_max[2]  = '{15, 255};
    int m_stop[2] = '{0, 1};
    int m_st[2];
    int m_cnt[2][4];
    int m_ecnt[2], m_err[2], m_p[2], m_fm[2], m_pq[2], m_pmode[2];
    int qt = 0;

    function automatic int jk_next(input int qv, input int mode);
        if (mode == 0) return qv;
        if (mode == 3) return 1 - qv;
        return mode >> 1;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v < mx) ? v + 1 : mx;
    endfunction

    task automatic model_reset(input int i);
        m_st[i] = 0; m_ecnt[i] = 0; m_err[i] = 0; m_p[i] = 0; m_fm[i] = 0;
        m_pq[i] = 0; m_pmode[i] = 0;
        for (int b = 0; b < 4; b++) m_cnt[i][b] = 0;
    endtask

    task automatic model_edge(input int i, input int e, input int mode, input int qv, input int qbv);
        int bad;
        m_p[i] = 0;
        if (m_st[i] == 2) return;
        if (e == 0) begin
            m_st[i] = 0;
            return;
        end
        m_cnt[i][mode] = sat(m_cnt[i][mode], m_max[i]);
        if (m_st[i] == 1) begin
            bad = (qv != jk_next(m_pq[i], m_pmode[i])) || (qbv == qv);
            if (bad != 0) begin
                m_p[i] = 1;
                if (m_err[i] == 0) m_fm[i] = m_pmode[i];
                m_err[i]  = 1;
                m_ecnt[i] = sat(m_ecnt[i], m_max[i]);
                if (m_stop[i] != 0) m_st[i] = 2;
            end
        end else begin
            m_st[i] = 1;
        end
        m_pq[i] = qv;
        m_pmode[i] = mode;
    endtask

    function automatic obs_t snap(input int i);
        obs_t o;
        o.h = m_cnt[i][0]; o.r = m_cnt[i][1]; o.s = m_cnt[i][2]; o.t = m_cnt[i][3];
        o.e = m_ecnt[i]; o.er = m_err[i]; o.p = m_p[i]; o.fm = m_fm[i]; o.st = m_st[i];
        return o;
    endfunction

    function automatic obs_t act(input int i);
        obs_t o;
        if (i == 0) begin
            o.h = int'(h0); o.r = int'(r0); o.s = int'(s0); o.t = int'(t0); o.e = int'(e0);
            o.er = int'(err0); o.p = int'(p0); o.fm = int'(fm0); o.st = int'(st0);
        end else begin
            o.h = int'(h1); o.r = int'(r1); o.s = int'(s1); o.t = int'(t1); o.e = int'(e1);
            o.er = int'(err1); o.p = int'(p1); o.fm = int'(fm1); o.st = int'(st1);
        end
        return o;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        n_chk++;
        if (got == want) n_pass++;
        else $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
    endtask

    task automatic cmp(input int i, input string tag, input obs_t a, input obs_t x);
        chk($sformatf("%s dut%0d hold_cnt", tag, i), a.h, x.h);
        chk($sformatf("%s dut%0d reset_cnt", tag, i), a.r, x.r);
        chk($sformatf("%s dut%0d set_cnt", tag, i), a.s, x.s);
        chk($sformatf("%s dut%0d toggle_cnt", tag, i), a.t, x.t);
        chk($sformatf("%s dut%0d err_cnt", tag, i), a.e, x.e);
        chk($sformatf("%s dut%0d err", tag, i), a.er, x.er);
        chk($sformatf("%s dut%0d err_pulse", tag, i), a.p, x.p);
        chk($sformatf("%s dut%0d first_err_mode", tag, i), a.fm, x.fm);
        chk($sformatf("%s dut%0d state", tag, i), a.st, x.st);
    endtask

    // Monitor: every falling edge, pop the expectation for the preceding rising edge.
    initial begin
        obs_t x;
        forever begin
            @(negedge clk);
            if (sb0.size() > 0) begin x = sb0.pop_front(); cmp(0, "sb", act(0), x); end
            if (sb1.size() > 0) begin x = sb1.pop_front(); cmp(1, "sb", act(1), x); end
        end
    end

    // cor: 0 clean, 1 observed q stuck at 0, 2 q_bar driven equal to q.
    task automatic step(input int e, input int mode, input int cor);
        int qv, qbv;
        @(negedge clk); #1;
        rst = 1'b1;
        qv  = (cor == 1) ? 0 : qt;
        qbv = (cor == 2) ? qv : 1 - qv;
        en = e[0]; j = mode[1]; k = mode[0]; q = qv[0]; q_bar = qbv[0];
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_edge(i, e, mode, qv, qbv);
        sb0.push_back(snap(0));
        sb1.push_back(snap(1));
        qt = jk_next(qv, mode);
    endtask

    task automatic do_reset();
        obs_t z;
        z = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        cmp(0, "async_reset", act(0), z);
        cmp(1, "async_reset", act(1), z);
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_reset(i);
        sb0.push_back(snap(0));
        sb1.push_back(snap(1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Ideal FF through every mode.
        do_reset();
        step(1, 0, 0); step(1, 1, 0); step(1, 0, 0);
        step(1, 2, 0); step(1, 0, 0); step(1, 3, 0);
        #1;
        chk("plan1 hold", int'(h0), 3);   chk("plan1 reset", int'(r0), 1);
        chk("plan1 set", int'(s0), 1);    chk("plan1 toggle", int'(t0), 1);
        chk("plan1 err_cnt", int'(e0), 0); chk("plan1 err", int'(err0), 0);
        chk("plan1 state", int'(st0), 1); chk("plan1 state dut1", int'(st1), 1);

        // q stuck at 0 after the set edge.
        do_reset();
        step(1, 0, 0); step(1, 1, 0); step(1, 0, 0); step(1, 2, 0);
        step(1, 0, 1);
        #1;
        chk("plan2 err_pulse", int'(p0), 1); chk("plan2 first_err_mode", int'(fm0), 2);
        step(1, 3, 0);
        #1;
        chk("plan2 pulse drop", int'(p0), 0);
        step(1, 0, 0); step(1, 3, 0);
        #1;
        chk("plan2 err_cnt", int'(e0), 1); chk("plan2 err", int'(err0), 1);
        chk("plan2 dut1 fault", int'(st1), 2);

        // Complement violation with correct q.
        do_reset();
        step(1, 0, 0); step(1, 2, 0); step(1, 0, 2); step(1, 0, 0); step(1, 3, 0);
        #1;
        chk("plan3 err_cnt", int'(e0), 1); chk("plan3 err", int'(err0), 1);

        // Saturation of the 4-bit toggle counter.
        do_reset();
        for (int n = 0; n < 20; n++) step(1, 3, 0);
        #1;
        chk("plan4 toggle sat", int'(t0), 15); chk("plan4 toggle wide", int'(t1), 20);
        chk("plan4 err_cnt", int'(e0), 0);

        // Stop-on-error freeze.
        do_reset();
        step(1, 2, 0); step(1, 0, 0); step(1, 0, 1);
        for (int n = 0; n < 5; n++) step(1, 0, 2);
        #1;
        chk("plan5 state", int'(st1), 2); chk("plan5 err_cnt", int'(e1), 1);
        chk("plan5 hold frozen", int'(h1), 2); chk("plan5 set frozen", int'(s1), 1);
        chk("plan5 free err_cnt", int'(e0), 6);

        // Enable drop while the flop keeps toggling.
        do_reset();
        for (int n = 0; n < 3; n++) step(1, 3, 0);
        step(0, 3, 0);
        #1;
        chk("plan6 idle", int'(st0), 0);
        step(0, 3, 0); step(0, 3, 0);
        step(1, 3, 0);
        #1;
        chk("plan6 recheck", int'(st0), 1);
        step(1, 3, 0); step(1, 3, 0);
        #1;
        chk("plan6 no false err", int'(e0), 0);

        // Randomised traffic with sparse fault injection and periodic resets.
        for (int n = 0; n < 400; n++) begin
            int e, mode, cor;
            if (n % 100 == 0) do_reset();
            e    = ($urandom_range(0, 7) != 0) ? 1 : 0;
            mode = int'($urandom_range(0, 3));
            cor  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0;
            step(e, mode, cor);
        end

        @(negedge clk); @(negedge clk); #1;
        chk("scoreboard drained", sb0.size() + sb1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jk_ff_monitor.md
Name: jk_ff_monitor

Overview:
- Clocked checker that sits directly downstream of a JK flip-flop stage built from D, SR or T flip-flops.
- Shares the flip-flop's clock and observes its J, K, Q and Q_bar.
- Predicts the next Q from a reference JK model, flags mismatches and complement violations, and counts hold/reset/set/toggle events.
- Used in self-checking benches and as an on-chip sanity monitor for the JK flip-flop family.

Parameters:
CNT_W, 8, width of every event and error counter
STOP_ON_ERR, 0, 1 = enter FAULT on first error and freeze all counters until reset

Ports:
clk  input  1  clock; all sampling on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  monitor enable
j  input  1  J applied to the observed flip-flop
k  input  1  K applied to the observed flip-flop
q  input  1  observed Q
q_bar  input  1  observed Q_bar
hold_cnt  output  CNT_W  edges sampled with {j,k}=00
reset_cnt  output  CNT_W  edges sampled with {j,k}=01
set_cnt  output  CNT_W  edges sampled with {j,k}=10
toggle_cnt  output  CNT_W  edges sampled with {j,k}=11
err_cnt  output  CNT_W  number of failing checks
err  output  1  sticky error flag
err_pulse  output  1  one-cycle pulse per failing check
first_err_mode  output  2  {j,k} mode that produced the first failing value
state  output  2  00 IDLE, 01 CHECK, 10 FAULT

Behaviour:
- Reset: rst=0 asynchronously clears all counters, err, err_pulse, first_err_mode, the internal exp_q and last_mode, and sets state to IDLE. Takes effect immediately, including mid-sequence.
- Reference model f(qv,j,k):
  - 00 → qv
  - 01 → 0
  - 10 → 1
  - 11 → ~qv
- Mode counting: every rising edge with en=1 in IDLE or CHECK increments the counter selected by sampled {j,k}.
- Counters saturate at 2^CNT_W−1 and never wrap.
- IDLE:
  - en=0: nothing changes.
  - en=1 at an edge: exp_q <= f(q,j,k), last_mode <= {j,k}, go to CHECK.
  - No comparison is made on this seeding edge.
- CHECK, each edge with en=1:
  - fail = (q != exp_q) OR (q_bar != ~q).
  - If fail: err_pulse <= 1 for exactly one cycle; err <= 1; err_cnt increments (saturating).
  - If fail and err was 0 before this edge: first_err_mode <= last_mode.
  - Then exp_q <= f(q,j,k), last_mode <= {j,k}. Resyncing to the observed q prevents cascaded errors.
  - If fail and STOP_ON_ERR=1: go to FAULT.
- CHECK, edge with en=0: go to IDLE; counters and err hold; next enable re-seeds.
- FAULT:
  - No counting and no checking; err_pulse=0.
  - Stays in FAULT regardless of en; exits only through reset.
- err_pulse is 0 on every edge without a fail.
- err clears only on reset.
- Timing: the observed flip-flop and exp_q update on the same edge, so a fault in the value produced at edge N is reported by err_pulse high during cycle N+1 to N+2 (registered, one-cycle latency after the checking edge).
- Simultaneous cases:
  - A Q mismatch and a Q_bar violation on the same edge count as one error.
  - en falling on the same edge that would fail: en=0 wins; no check, go to IDLE.
- X/Z on q or q_bar in CHECK counts as a fail.

Test Plan:
1. Ideal JK FF, clk period 10. rst=0 for 5 ns, then en=1 with {j,k} for one cycle each: 00, 01, 00, 10, 00, 11 → hold_cnt=3, reset_cnt=1, set_cnt=1, toggle_cnt=1, err_cnt=0, err=0, state=CHECK.
2. Faulty DUT: q stuck at 0 during the set step of scenario 1 → err_pulse high for exactly one cycle after the checking edge, err=1, err_cnt=1, first_err_mode=2'b10. With STOP_ON_ERR=0 the following hold/toggle steps produce no further errors.
3. Force q_bar=q for one cycle while q is correct → err_cnt=1 and err=1; err_pulse is a single cycle.
4. Saturation: CNT_W=4, 20 consecutive toggle cycles → toggle_cnt=15 (held, no wrap) and err_cnt=0.
5. STOP_ON_ERR=1: inject a fault, then 5 more faulty cycles → state=FAULT, err_cnt=1, and all mode counters frozen at their values from the failing edge.
6. Control and reset:
   - Drop en for 3 cycles while the DUT toggles, then re-assert → state returns to IDLE then CHECK, with no false error.
   - Assert rst=0 mid-sequence → all outputs 0 asynchronously, before the next clock edge.
